dec_counter: RTL and testbench
==============================

// Module: dec_counter
// PURPOSE
// - Loadable, sequential down-counter/timer: the registered successor to the combinational decrementer.
// - Decrements by a runtime step (not only 1), saturates at zero or auto-reloads, and flags terminal count.
// - Used as event/timeout counter in datapaths built from the arithmetic library.
// PARAMETERS
// - width      8                  counter/load value width, >= 2
// - stepWidth  1                  step_i width, 1 <= stepWidth <= width
// - speed      lau_pkg::FAST      performance parameter, passed to internal Dec/prefix logic
// PORTS
// - clk_i    in   1          clock, all state updates on rising edge
// - rst_i    in   1          reset, synchronous, active-high
// - load_i   in   1          load cnt and reload register from value_i, latch mode_i
// - value_i  in   width      load value
// - mode_i   in   1          0 = ONESHOT (stop at zero), 1 = RELOAD (auto-reload at zero)
// - en_i     in   1          count enable
// - step_i   in   stepWidth  decrement amount per enabled cycle
// - cnt_o    out  width      current count (registered)
// - zero_o   out  1          cnt_o == 0 (combinational from register)
// - tc_o     out  1          terminal-count pulse, registered, one cycle
// - busy_o   out  1          state == RUN
// BEHAVIOUR
// - Reset: cnt_o=0, reload reg=0, mode reg=ONESHOT, state=IDLE, tc_o=0, busy_o=0, zero_o=1.
// - States: IDLE, RUN. Everything registered; load/decrement visible on cnt_o 1 cycle after the edge.
// - load_i=1 (any state): cnt<=value_i, reload<=value_i, mode<=mode_i; state<=RUN if value_i!=0 else IDLE.
//   Load has priority over en_i in the same cycle; no decrement that cycle; tc_o<=0.
// - RUN & en_i & !load_i:
//   - step_i==0: no change, tc_o<=0.
//   - cnt > step_i: cnt<=cnt-step_i, tc_o<=0.
//   - cnt <= step_i (reaches/passes zero): tc_o<=1 next cycle.
//     ONESHOT: cnt<=0, state<=IDLE (saturate, no wrap).
//     RELOAD: cnt<=reload (remainder discarded), stay RUN.
// - RUN & !en_i: hold, tc_o<=0. IDLE: cnt holds, en_i ignored, tc_o<=0.
// - Arithmetic: step_i zero-extended to width; cnt never wraps below 0.
//   stepWidth==1 path uses the prefix Dec (cnt-1) with speed.
// - tc_o is high exactly in the cycle cnt_o first shows the post-terminal value (0 or reload).
//   Never high two consecutive cycles unless RELOAD with reload<=step_i on back-to-back enables.
// - rst_i mid-count overrides load_i/en_i; next cycle equals reset state, tc_o=0.
// CONFIGURATION
// - LAU_DEC_COUNTER_PRESCALE_EN defined:
//   - Adds localparam presWidth=4 and input pres_i[presWidth-1:0].
//   - Internal prescaler counts enabled RUN cycles; decrement happens only on every (pres_i+1)-th one.
//   - Prescaler cleared by rst_i, load_i and every decrement event; pres_i==0 behaves as no prescale.
// - Undefined: no pres_i port; decrement on every enabled RUN cycle.
// TESTING
// - Reset: assert rst_i 2 cycles mid-count (cnt=5) -> cnt_o=0, zero_o=1, busy_o=0, tc_o=0.
// - ONESHOT step 1: load 3, en_i=1 -> cnt_o 3,2,1,0; tc_o high only with 0; busy_o falls with it; further en_i holds 0.
// - RELOAD multi-step (stepWidth=3): load 10, mode=1, step_i=4 -> cnt_o 10,6,2,10,6; tc_o high on each 2->10.
// - Saturation: load 3 ONESHOT, step_i=7 -> next cnt_o=0, tc_o=1, no wrap to 252.
// - Load/enable collision: cnt=5 RUN, load_i=1 value_i=9 with en_i=1 -> cnt_o=9, tc_o=0; load 0 -> IDLE, zero_o=1.
// - Prescale (macro on): load 2, pres_i=2, en_i=1 -> cnt_o decrements every 3rd cycle, reaches 0 after 6 cycles.

Source files
------------

// File: rtl/dec_counter.sv
// dec_counter: loadable down-counter/timer with runtime step, saturating
// (ONESHOT) or auto-reloading (RELOAD) terminal behaviour and a one-cycle
// registered terminal-count pulse.
// Optional build macro: LAU_DEC_COUNTER_PRESCALE_EN adds pres_i and an
// internal prescaler so only every (pres_i+1)-th enabled RUN cycle decrements.

package lau_pkg;
  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_e;
endpackage

module dec_counter #(
  parameter int              width     = 8,
  parameter int              stepWidth = 1,
  parameter lau_pkg::speed_e speed     = lau_pkg::FAST
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
  ,
  localparam int             presWidth = 4
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [width-1:0]     value_i,
  input  logic                 mode_i,
  input  logic                 en_i,
  input  logic [stepWidth-1:0] step_i,
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
  input  logic [presWidth-1:0] pres_i,
`endif
  output logic [width-1:0]     cnt_o,
  output logic                 zero_o,
  output logic                 tc_o,
  output logic                 busy_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_r, state_s;
  logic [width-1:0]   cnt_r, cnt_s;
  logic [width-1:0]   reload_r, reload_s;
  logic               mode_r, mode_s;
  logic               tc_r, tc_s;
  logic [width-1:0]   step_ext_s;
  logic [width-1:0]   dec_s;
  logic               tick_s;

`ifdef LAU_DEC_COUNTER_PRESCALE_EN
  logic [presWidth-1:0] pres_cnt_r, pres_cnt_s;
`endif

  // Zero-extend the step to the counter width.
  always_comb begin
    step_ext_s                  = {width{1'b0}};
    step_ext_s[stepWidth-1:0]   = step_i;
  end

  // Decremented count: dedicated cnt-1 logic for unit steps, general subtract otherwise.
  generate
    if (stepWidth == 1) begin : g_unit
      if (speed == lau_pkg::FAST) begin : g_fast
        logic [width-1:0] zpre_s;
        // Parallel prefix AND of the zero bits gives each bit's borrow-in in log depth.
        always_comb begin
          zpre_s = ~cnt_r;
          for (int s = 1; s < width; s = s * 2) begin
            for (int i = width - 1; i >= 0; i--) begin
              if (i >= s) begin
                zpre_s[i] = zpre_s[i] & zpre_s[i-s];
              end else begin
                zpre_s[i] = zpre_s[i];
              end
            end
          end
          dec_s = cnt_r ^ {zpre_s[width-2:0], 1'b1};
        end
      end else begin : g_slow
        logic borrow_s;
        // Ripple-borrow decrement by one.
        always_comb begin
          borrow_s = 1'b1;
          dec_s    = {width{1'b0}};
          for (int i = 0; i < width; i++) begin
            dec_s[i] = cnt_r[i] ^ borrow_s;
            borrow_s = borrow_s & ~cnt_r[i];
          end
        end
      end
    end else begin : g_multi
      // Multi-bit step subtract; only used when cnt exceeds the step, so never wraps.
      always_comb begin
        dec_s = cnt_r - step_ext_s;
      end
    end
  endgenerate

`ifdef LAU_DEC_COUNTER_PRESCALE_EN
  // Decrement only on the (pres_i+1)-th enabled RUN cycle since the last clear.
  always_comb begin
    tick_s = (pres_cnt_r == pres_i);
  end
`else
  // Without prescaling every enabled RUN cycle is a decrement event.
  always_comb begin
    tick_s = 1'b1;
  end
`endif

  // Next-state logic: load beats count; terminal count saturates or reloads.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    mode_s   = mode_r;
    tc_s     = 1'b0;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    pres_cnt_s = pres_cnt_r;
`endif
    if (load_i) begin
      cnt_s    = value_i;
      reload_s = value_i;
      mode_s   = mode_i;
      state_s  = (value_i != {width{1'b0}}) ? RUN : IDLE;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
      pres_cnt_s = {presWidth{1'b0}};
`endif
    end else if ((state_r == RUN) && en_i) begin
      if (!tick_s) begin
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
        pres_cnt_s = pres_cnt_r + {{(presWidth-1){1'b0}}, 1'b1};
`endif
      end else begin
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
        pres_cnt_s = {presWidth{1'b0}};
`endif
        if (step_ext_s == {width{1'b0}}) begin
          cnt_s = cnt_r;
        end else if (cnt_r > step_ext_s) begin
          cnt_s = dec_s;
        end else begin
          tc_s = 1'b1;
          case (mode_r)
            1'b1: begin
              cnt_s = reload_r;
            end
            1'b0: begin
              cnt_s   = {width{1'b0}};
              state_s = IDLE;
            end
            default: begin
              cnt_s   = {width{1'b0}};
              state_s = IDLE;
            end
          endcase
        end
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= {width{1'b0}};
      reload_r <= {width{1'b0}};
      mode_r   <= 1'b0;
      tc_r     <= 1'b0;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
      pres_cnt_r <= {presWidth{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      tc_r     <= tc_s;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
      pres_cnt_r <= pres_cnt_s;
`endif
    end
  end

  assign cnt_o  = cnt_r;
  assign zero_o = (cnt_r == {width{1'b0}});
  assign tc_o   = tc_r;
  assign busy_o = (state_r == RUN);

endmodule

// File: tb/tb_dec_counter.sv
// Self-checking bench for dec_counter: three instances (3-bit step, unit
// step FAST, unit step SLOW) share stimulus and are compared every cycle
// against a behavioural integer model of the counting rules.
module tb_dec_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, mode, en;
  logic [7:0] value;
  logic [2:0] step;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
  logic [3:0] pres;
`endif

  logic [7:0] cnt_o  [3];
  logic       zero_o [3];
  logic       tc_o   [3];
  logic       busy_o [3];

  int checks   = 0;
  int failures = 0;

  int m_cnt [3];
  int m_rel [3];
  int m_mode[3];
  int m_run [3];
  int m_tc  [3];
  int m_pc  [3];

  dec_counter #(.width(8), .stepWidth(3), .speed(lau_pkg::FAST)) u_a (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .mode_i(mode),
    .en_i(en), .step_i(step),
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    .pres_i(pres),
`endif
    .cnt_o(cnt_o[0]), .zero_o(zero_o[0]), .tc_o(tc_o[0]), .busy_o(busy_o[0]));

  dec_counter #(.width(8), .stepWidth(1), .speed(lau_pkg::FAST)) u_b (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .mode_i(mode),
    .en_i(en), .step_i(step[0:0]),
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    .pres_i(pres),
`endif
    .cnt_o(cnt_o[1]), .zero_o(zero_o[1]), .tc_o(tc_o[1]), .busy_o(busy_o[1]));

  dec_counter #(.width(8), .stepWidth(1), .speed(lau_pkg::SLOW)) u_c (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value), .mode_i(mode),
    .en_i(en), .step_i(step[0:0]),
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    .pres_i(pres),
`endif
    .cnt_o(cnt_o[2]), .zero_o(zero_o[2]), .tc_o(tc_o[2]), .busy_o(busy_o[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one clock edge's worth of the counting rules to the model.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s;
      int p;
      s = (k == 0) ? int'(step) : int'(step[0]);
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
      p = int'(pres);
`else
      p = 0;
`endif
      if (rst) begin
        m_cnt[k] = 0; m_rel[k] = 0; m_mode[k] = 0; m_run[k] = 0; m_tc[k] = 0; m_pc[k] = 0;
      end else if (load) begin
        m_cnt[k] = int'(value); m_rel[k] = int'(value); m_mode[k] = int'(mode);
        m_run[k] = (value != 8'd0) ? 1 : 0; m_tc[k] = 0; m_pc[k] = 0;
      end else if (m_run[k] == 1 && en) begin
        m_tc[k] = 0;
        if (m_pc[k] < p) begin
          m_pc[k]++;
        end else begin
          m_pc[k] = 0;
          if (s == 0) begin
            m_tc[k] = 0;
          end else if (m_cnt[k] > s) begin
            m_cnt[k] = m_cnt[k] - s;
          end else begin
            m_tc[k] = 1;
            if (m_mode[k] == 1) m_cnt[k] = m_rel[k];
            else begin m_cnt[k] = 0; m_run[k] = 0; end
          end
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cnt[%0d]", k),  int'(cnt_o[k]),  m_cnt[k]);
      chk($sformatf("zero[%0d]", k), int'(zero_o[k]), (m_cnt[k] == 0) ? 1 : 0);
      chk($sformatf("tc[%0d]", k),   int'(tc_o[k]),   m_tc[k]);
      chk($sformatf("busy[%0d]", k), int'(busy_o[k]), m_run[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; en = 1'b0; value = 8'd0; step = 3'd0;
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    pres = 4'd0;
`endif
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_mode[k] = 0; m_run[k] = 0; m_tc[k] = 0; m_pc[k] = 0;
    end
    cyc(); cyc();
    chk("reset_zero", int'(zero_o[0]), 1);

    // Reset mid-count: cnt=5 RUN, then two reset cycles.
    rst = 1'b0; load = 1'b1; value = 8'd5; mode = 1'b0;
    cyc();
    load = 1'b0; cyc();
    chk("held5", int'(cnt_o[0]), 5);
    rst = 1'b1; load = 1'b1; en = 1'b1; step = 3'd1;
    cyc(); cyc();
    chk("rst_cnt", int'(cnt_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);

    // ONESHOT step 1: 3,2,1,0 then hold.
    rst = 1'b0; load = 1'b1; value = 8'd3; en = 1'b1; step = 3'd1;
    cyc();
    load = 1'b0;
    cyc(); cyc(); cyc();
    chk("os_zero", int'(cnt_o[1]), 0);
    chk("os_tc", int'(tc_o[1]), 1);
    cyc(); cyc();
    chk("os_hold_tc", int'(tc_o[2]), 0);

    // RELOAD multi-step: 10,6,2,10,6.
    load = 1'b1; value = 8'd10; mode = 1'b1; step = 3'd4;
    cyc();
    load = 1'b0;
    cyc(); cyc(); cyc();
    chk("rl_reload", int'(cnt_o[0]), 10);
    chk("rl_tc", int'(tc_o[0]), 1);
    cyc(); cyc(); cyc(); cyc();

    // Saturation: load 3 ONESHOT, step 7 -> 0, no wrap.
    load = 1'b1; value = 8'd3; mode = 1'b0; step = 3'd7;
    cyc();
    load = 1'b0; cyc();
    chk("sat_cnt", int'(cnt_o[0]), 0);
    chk("sat_tc", int'(tc_o[0]), 1);

    // Load/enable collision then load 0.
    load = 1'b1; value = 8'd5; step = 3'd1;
    cyc();
    value = 8'd9; cyc();
    chk("coll_cnt", int'(cnt_o[0]), 9);
    value = 8'd0; cyc();
    chk("load0_busy", int'(busy_o[0]), 0);
    load = 1'b0; cyc(); cyc();

`ifdef LAU_DEC_COUNTER_PRESCALE_EN
    // Prescale by 3: load 2 reaches 0 after 6 enabled cycles.
    pres = 4'd2; load = 1'b1; value = 8'd2; step = 3'd1; en = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("pres_done", int'(cnt_o[1]), 0);
    pres = 4'd0;
`endif

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 60) == 0);
      load  = ($urandom_range(0, 9) == 0);
      value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      mode  = 1'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      step  = 3'($urandom);
`ifdef LAU_DEC_COUNTER_PRESCALE_EN
      pres  = 4'($urandom_range(0, 3));
`endif
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
